// File: rtl/team_06_audio_pkg.sv
// Shared audio-path types and constants for the team_06 sample feeder.
package team_06_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    localparam logic [SAMPLE_W-1:0] MUTE_SAMPLE = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/team_06_sync_fifo.sv
// Single-clock FIFO with occupancy count; synchronous flush, pointers wrap modulo DEPTH.
module team_06_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/team_06_sample_feeder.sv
// Buffers processed samples and hands one word per serializer strobe, with prime/underrun control.
// Build option: define TEAM_06_FEEDER_HOLD_LAST_EN to repeat the last sample on underrun (else mute).
module team_06_sample_feeder
    import team_06_audio_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PRIME_LEVEL = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   enable,
    input  logic [15:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   word_req,
    output logic [15:0]            parallel_out,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   underrun,
    input  logic                   clear_underrun
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(PRIME_LEVEL);

    feeder_state_e       state_q, state_d;
    logic [SAMPLE_W-1:0] pout_q, pout_d;
    logic [SAMPLE_W-1:0] head, fill_sample;
    logic                underrun_q, underrun_d;
    logic                full, empty, push, pop, underrun_evt;

    assign in_ready     = nrst && enable && !full;
    assign push         = in_valid && in_ready;
    assign pop          = enable && word_req && (state_q == RUN) && !empty;
    assign underrun_evt = enable && word_req && (state_q == RUN) && empty;

`ifdef TEAM_06_FEEDER_HOLD_LAST_EN
    // Underrun only happens in RUN after a pop, so the output register still holds that sample.
    assign fill_sample = pout_q;
`else
    assign fill_sample = MUTE_SAMPLE;
`endif

    team_06_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .flush (!enable),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

    always_comb begin
        state_d    = state_q;
        pout_d     = pout_q;
        underrun_d = underrun_q;

        if (clear_underrun) underrun_d = 1'b0;
        if (underrun_evt)   underrun_d = 1'b1;

        if (word_req) begin
            if (pop)               pout_d = head;
            else if (underrun_evt) pout_d = fill_sample;
            else                   pout_d = MUTE_SAMPLE;
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (fill_level >= PRIME_CNT) state_d = RUN;
                RUN:     if (underrun_evt) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            pout_q     <= MUTE_SAMPLE;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pout_q     <= pout_d;
            underrun_q <= underrun_d;
        end
    end

    assign parallel_out = pout_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_team_06_sample_feeder.sv
// Self-checking bench for team_06_sample_feeder: scoreboard model plus table of mixed push/pop ops.
module tb_team_06_sample_feeder;
    import team_06_audio_pkg::*;

    localparam int DEPTH       = 8;
    localparam int PRIME_LEVEL = 4;
`ifdef TEAM_06_FEEDER_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk;
    logic        nrst;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        word_req;
    logic [15:0] parallel_out;
    logic [3:0]  fill_level;
    logic        underrun;
    logic        clear_underrun;

    team_06_sample_feeder #(
        .DEPTH       (DEPTH),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .enable         (enable),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .word_req       (word_req),
        .parallel_out   (parallel_out),
        .fill_level     (fill_level),
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        w;
        logic        clr;
        int          fill;
        logic        ur;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    logic [15:0]   sb[$];
    feeder_state_e m_st;
    logic [15:0]   m_out;
    logic [15:0]   m_last;
    logic          m_ur;
    vec_t          tbl[20];
    logic [15:0]   prime_vals[4];

    function automatic vec_t mk(logic v, logic [15:0] d, logic w, logic clr, int fill, logic ur);
        vec_t r;
        r.v = v; r.d = d; r.w = w; r.clr = clr; r.fill = fill; r.ur = ur;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_st   = IDLE;
        m_out  = 16'h0000;
        m_last = 16'h0000;
        m_ur   = 1'b0;
    endtask

    // One clock of the reference model, then compare every output 1 time unit after the edge.
    task automatic step();
        int            n_before = sb.size();
        bit            acc      = nrst && enable && in_valid && (n_before < DEPTH);
        bit            ur_evt   = 1'b0;
        logic [15:0]   exp_out  = m_out;
        feeder_state_e nst      = m_st;
        logic          nur;
        if (word_req) begin
            if (enable && m_st == RUN && n_before > 0) begin
                exp_out = sb.pop_front();
                m_last  = exp_out;
            end else if (enable && m_st == RUN) begin
                ur_evt  = 1'b1;
                exp_out = HOLD ? m_last : 16'h0000;
            end else begin
                exp_out = 16'h0000;
            end
        end
        if (acc) sb.push_back(in_data);
        if (!enable) begin
            nst = IDLE;
            sb.delete();
        end else begin
            case (m_st)
                IDLE:    nst = PRIME;
                PRIME:   if (n_before >= PRIME_LEVEL) nst = RUN;
                RUN:     if (ur_evt) nst = PRIME;
                default: nst = IDLE;
            endcase
        end
        nur = ur_evt ? 1'b1 : (clear_underrun ? 1'b0 : m_ur);
        @(posedge clk);
        #1;
        m_st  = nst;
        m_out = exp_out;
        m_ur  = nur;
        chk("parallel_out", 32'(parallel_out), 32'(m_out));
        chk("fill_level", 32'(fill_level), 32'(sb.size()));
        chk("underrun", 32'(underrun), 32'(m_ur));
        chk("in_ready", 32'(in_ready), 32'(nrst && enable && (sb.size() < DEPTH)));
    endtask

    task automatic push_one(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic strobe();
        word_req = 1'b1;
        step();
        word_req = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pout"}, 32'(parallel_out), 32'h0);
        chk({tag, "_fill"}, 32'(fill_level), 32'h0);
        chk({tag, "_underrun"}, 32'(underrun), 32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 16'hC001, 1'b0, 1'b0, 1, 1'b0);
        tbl[1]  = mk(1'b1, 16'hC002, 1'b0, 1'b0, 2, 1'b0);
        tbl[2]  = mk(1'b1, 16'hC003, 1'b0, 1'b0, 3, 1'b0);
        tbl[3]  = mk(1'b1, 16'hC004, 1'b1, 1'b0, 3, 1'b0);
        tbl[4]  = mk(1'b1, 16'hC005, 1'b1, 1'b0, 3, 1'b0);
        tbl[5]  = mk(1'b1, 16'hC006, 1'b1, 1'b0, 3, 1'b0);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0);
        tbl[7]  = mk(1'b1, 16'hC007, 1'b0, 1'b0, 3, 1'b0);
        tbl[8]  = mk(1'b1, 16'hC008, 1'b1, 1'b0, 3, 1'b0);
        tbl[9]  = mk(1'b1, 16'hC009, 1'b1, 1'b0, 3, 1'b0);
        tbl[10] = mk(1'b1, 16'hC00A, 1'b0, 1'b0, 4, 1'b0);
        tbl[11] = mk(1'b1, 16'hC00B, 1'b1, 1'b0, 4, 1'b0);
        tbl[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0);
        tbl[13] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0);
        tbl[14] = mk(1'b1, 16'hC00C, 1'b1, 1'b0, 2, 1'b0);
        tbl[15] = mk(1'b1, 16'hC00D, 1'b1, 1'b0, 2, 1'b0);
        tbl[16] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
        tbl[17] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        // Empty in RUN with push and strobe together, clear asserted: underrun set wins, sample kept.
        tbl[18] = mk(1'b1, 16'hC00E, 1'b1, 1'b1, 1, 1'b1);
        tbl[19] = mk(1'b1, 16'hC00F, 1'b1, 1'b0, 2, 1'b1);
        prime_vals[0] = 16'hD9D3;
        prime_vals[1] = 16'h99B3;
        prime_vals[2] = 16'h1234;
        prime_vals[3] = 16'h8000;

        nrst           = 1'b0;
        enable         = 1'b1;
        in_data        = 16'h0000;
        in_valid       = 1'b0;
        word_req       = 1'b0;
        clear_underrun = 1'b0;
        model_reset();

        // Reset, then prime with four samples and read them back in order.
        #400;
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) push_one(prime_vals[i]);
        chk("prime_state_before", 32'(dut.state_q), 32'(PRIME));
        step();
        chk("prime_state_run", 32'(dut.state_q), 32'(RUN));
        for (int i = 0; i < 4; i++) begin
            strobe();
            chk("prime_order", 32'(parallel_out), 32'(prime_vals[i]));
            step();
            chk("prime_hold", 32'(parallel_out), 32'(prime_vals[i]));
        end

        // Underrun on an empty FIFO in RUN, then clear.
        strobe();
        chk("ur_flag", 32'(underrun), 32'h1);
        chk("ur_state", 32'(dut.state_q), 32'(PRIME));
        chk("ur_fill_value", 32'(parallel_out), HOLD ? 32'h8000 : 32'h0);
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        chk("ur_cleared", 32'(underrun), 32'h0);

        // Fill to capacity; the ninth sample must be refused.
        for (int i = 0; i < 8; i++) push_one(16'hA000 + 16'(i));
        chk("full_fill", 32'(fill_level), 32'd8);
        chk("full_ready", 32'(in_ready), 32'h0);
        push_one(16'hBAD0);
        chk("full_fill_after_9th", 32'(fill_level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            strobe();
            chk("full_readout", 32'(parallel_out), 32'(16'hA000 + 16'(i)));
        end
        chk("full_drained", 32'(fill_level), 32'd0);

        // Mixed simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            in_valid       = tbl[i].v;
            in_data        = tbl[i].d;
            word_req       = tbl[i].w;
            clear_underrun = tbl[i].clr;
            step();
            chk("tbl_fill", 32'(fill_level), 32'(tbl[i].fill));
            chk("tbl_underrun", 32'(underrun), 32'(tbl[i].ur));
        end
        in_valid       = 1'b0;
        word_req       = 1'b0;
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;

        // Mid-operation asynchronous reset with five samples queued.
        for (int i = 0; i < 4; i++) push_one(16'hD001 + 16'(i));
        strobe();
        chk("midrst_state", 32'(dut.state_q), 32'(RUN));
        chk("midrst_fill", 32'(fill_level), 32'd5);
        #3;
        nrst = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("midrst_now");
        #1000;
        chk_reset_vals("midrst_hold");
        nrst = 1'b1;
        strobe();
        chk("post_rst_mute0", 32'(parallel_out), 32'h0);
        strobe();
        chk("post_rst_mute1", 32'(parallel_out), 32'h0);
        for (int i = 0; i < 4; i++) push_one(16'hE001 + 16'(i));
        step();
        strobe();
        chk("post_rst_reprimed", 32'(parallel_out), 32'hE001);

        // Drop enable in RUN with three queued.
        chk("dis_pre_fill", 32'(fill_level), 32'd3);
        enable = 1'b0;
        step();
        chk("dis_fill", 32'(fill_level), 32'd0);
        chk("dis_state", 32'(dut.state_q), 32'(IDLE));
        strobe();
        chk("dis_mute", 32'(parallel_out), 32'h0);
        enable = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/team_06_sample_feeder.md
TEAM_06_SAMPLE_FEEDER -- requirements
Module: team_06_sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in samples; power of two, range 4..32.
REQ-002 SHALL have parameter PRIME_LEVEL, default 4, fill level required before output starts; range 1..DEPTH.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port nrst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, run request; low forces IDLE.
REQ-006 SHALL have port in_data, input, 16, signed sample from the processing chain.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, feeder accepts in_data this cycle.
REQ-009 SHALL have port word_req, input, 1, one-clk strobe from the I2S serializer at each word boundary.
REQ-010 SHALL have port parallel_out, output, 16, sample word held for the serializer.
REQ-011 SHALL have port fill_level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port underrun, output, 1, sticky underrun flag.
REQ-013 SHALL have port clear_underrun, input, 1, synchronous clear of underrun.

Function
REQ-014 SHALL push in_data when in_valid && in_ready; in_ready = (fill_level != DEPTH) && enable, combinational from registered count.
REQ-015 SHALL use FSM states IDLE, PRIME, RUN.
- IDLE -> PRIME when enable = 1.
- PRIME -> RUN when fill_level >= PRIME_LEVEL.
- Any state -> IDLE when enable = 0, which also flushes the FIFO.
REQ-016 SHALL update parallel_out only on the clock edge that samples word_req = 1; it holds constant between strobes; latency is 1 clk.
REQ-017 In RUN, with word_req = 1 and FIFO non-empty, SHALL pop the head into parallel_out.
REQ-018 In RUN, with word_req = 1 and FIFO empty, SHALL:
- set underrun;
- load the fill value per REQ-027;
- transition to PRIME.
REQ-019 In IDLE or PRIME, with word_req = 1, SHALL load 16'h0000 into parallel_out, with no pop and no underrun.
REQ-020 A simultaneous push and pop SHALL both take effect; fill_level is unchanged.
REQ-021 When full, in_ready SHALL be 0 even if a pop occurs the same cycle; no same-cycle pass-through.
REQ-022 When empty, a simultaneous push and word_req SHALL be treated as underrun (REQ-018); the pushed sample is stored.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; fill_level SHALL count 0..DEPTH inclusive.
REQ-024 clear_underrun SHALL clear underrun; if it coincides with a new underrun event, set wins.

Reset
REQ-025 While nrst = 0, SHALL hold:
- state = IDLE;
- pointers = 0, fill_level = 0;
- parallel_out = 16'h0000;
- underrun = 0, in_ready = 0.
REQ-026 Reset asserted mid-operation SHALL discard FIFO contents immediately; after release, the block SHALL restart from IDLE.

Configuration
REQ-027 Macro TEAM_06_FEEDER_HOLD_LAST_EN:
- Defined: an underrun reloads the last popped sample into parallel_out (repeat-last concealment).
- Undefined: an underrun loads 16'h0000 (mute).
- In both cases the underrun flag behaviour is identical.

Structure
REQ-028 Package team_06_audio_pkg SHALL hold:
- SAMPLE_W = 16;
- the feeder state enum (IDLE, PRIME, RUN);
- the 16'h0000 mute constant.
REQ-029 Storage and pointers SHALL live in sub-module team_06_sync_fifo (push/pop/full/empty/count). The FSM and output register stay in the feeder top.

Verification
REQ-030 Reset then prime:
- Stimulus: nrst low 400 ns, then enable = 1; push 0xD9D3, 0x99B3, 0x1234, 0x8000.
- Required: state reaches RUN after the 4th push.
- Required: successive word_req strobes yield parallel_out 0xD9D3, 0x99B3, 0x1234, 0x8000, each 1 clk after its strobe.
REQ-031 Full:
- Stimulus: push 8 samples with no word_req.
- Required: fill_level = 8, in_ready = 0.
- Required: a 9th in_valid is not stored; it is not seen on readout.
REQ-032 Underrun:
- Stimulus: in RUN, drain the FIFO, then one more word_req.
- Required: underrun = 1, state = PRIME.
- Required: parallel_out = last sample with the macro defined, 0x0000 without.
- Required: clear_underrun then drops the flag.
REQ-033 Simultaneous:
- Stimulus: fill_level = 3, push and word_req in the same cycle.
- Required: fill_level stays 3; order is preserved across 20 mixed operations, including pointer wrap.
REQ-034 Mid-operation reset:
- Stimulus: in RUN with 5 queued, pulse nrst low 1 µs asynchronously to clk.
- Required: outputs go to reset values immediately.
- Required: after release, word_req yields 0x0000 until re-primed.
REQ-035 Disable:
- Stimulus: enable dropped in RUN with 3 queued.
- Required: fill_level = 0 next cycle, state = IDLE.
